// File: rtl/servo_position_sequencer.sv
// Servo position sequencer: arbitrates the centre/left/right buttons and the
// sweep switch, ramps the 20-bit PWM select word in clamped steps on an
// internal update tick, and drives the status LEDs and limit flag.
module servo_position_sequencer #(
    parameter int unsigned TICK_DIV   = 1000000,
    parameter logic [19:0] POS_MIN    = 20'h0AFC8,
    parameter logic [19:0] POS_MAX    = 20'h19A28,
    parameter logic [19:0] POS_CENTER = 20'h124F8,
    parameter logic [19:0] DELTA      = 20'h001F4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BC,
    input  logic        BL,
    input  logic        BR,
    input  logic        SWEEP,
    output logic [19:0] POS,
    output logic [2:0]  LEDS,
    output logic        AT_LIMIT,
    output logic        TICK
);

    localparam int unsigned        CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic               DIR_LEFT  = 1'b0;
    localparam logic               DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_CENTER = 3'd1,
        ST_MOVE_L = 3'd2,
        ST_MOVE_R = 3'd3,
        ST_SWEEP  = 3'd4
    } state_t;

    // Request bundle order: {centre, left, right, sweep}
    logic [3:0]       sync_meta_q;
    logic [3:0]       sync_q;
    logic             s_bc, s_bl, s_br, s_sw;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    state_t           state_q, state_d;
    logic [19:0]      pos_q, pos_d;
    logic             dir_q, dir_d;
    logic [2:0]       leds_q, leds_d;
    logic             at_limit_q, at_limit_d;

    // One step toward POS_MIN. The floor test happens before subtracting so
    // the result can never wrap; a partial final step lands exactly on POS_MIN.
    function automatic logic [19:0] step_down(input logic [19:0] p);
        logic [20:0] floor_w;
        floor_w = {1'b0, POS_MIN} + {1'b0, DELTA};
        if ({1'b0, p} >= floor_w)
            return p - DELTA;
        else
            return POS_MIN;
    endfunction

    // One step toward POS_MAX, summed at 21 bits and clamped before use.
    function automatic logic [19:0] step_up(input logic [19:0] p);
        logic [20:0] sum_w;
        sum_w = {1'b0, p} + {1'b0, DELTA};
        if (sum_w >= {1'b0, POS_MAX})
            return POS_MAX;
        else
            return sum_w[19:0];
    endfunction

    function automatic logic is_limit(input logic [19:0] p);
        return (p <= POS_MIN) || (p >= POS_MAX);
    endfunction

    assign s_bc = sync_q[3];
    assign s_bl = sync_q[2];
    assign s_br = sync_q[1];
    assign s_sw = sync_q[0];

    // Two-flop synchronizers for the asynchronous button and switch levels
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= {BC, BL, BR, SWEEP};
            sync_q      <= sync_meta_q;
        end
    end

    // Free-running prescaler; wraps on the tick cycle, never restarted by requests
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign TICK = tick;

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_HOLD;
        else     state_q <= state_d;
    end

    // Next state: fixed-priority arbitration of the synced requests every cycle
    always_comb begin
        state_d = ST_HOLD;
        if (s_bc)      state_d = ST_CENTER;
        else if (s_bl) state_d = ST_MOVE_L;
        else if (s_br) state_d = ST_MOVE_R;
        else if (s_sw) state_d = ST_SWEEP;
    end

    // Outputs: position step for the current state, sweep reversal, LEDs, limit flag
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        case (state_q)
            ST_CENTER: pos_d = POS_CENTER;
            ST_MOVE_L: if (tick) pos_d = step_down(pos_q);
            ST_MOVE_R: if (tick) pos_d = step_up(pos_q);
            ST_SWEEP: begin
                if (tick) begin
                    // Reverse on the very step that reaches a limit so the
                    // following tick already moves away from it.
                    if (dir_q == DIR_RIGHT) begin
                        pos_d = step_up(pos_q);
                        if (pos_d >= POS_MAX) dir_d = DIR_LEFT;
                    end else begin
                        pos_d = step_down(pos_q);
                        if (pos_d <= POS_MIN) dir_d = DIR_RIGHT;
                    end
                end
            end
            default: pos_d = pos_q;
        endcase

        // LEDs follow the state being entered so they line up with the state register
        case (state_d)
            ST_CENTER: leds_d = 3'b010;
            ST_MOVE_L: leds_d = 3'b100;
            ST_MOVE_R: leds_d = 3'b001;
            ST_SWEEP:  leds_d = (dir_d == DIR_RIGHT) ? 3'b001 : 3'b100;
            default:   leds_d = 3'b000;
        endcase

        at_limit_d = is_limit(pos_d);
    end

    // Output registers: POS, direction, LEDs and limit flag update together
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos_q      <= POS_CENTER;
            dir_q      <= DIR_RIGHT;
            leds_q     <= 3'b000;
            at_limit_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            leds_q     <= leds_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign POS      = pos_q;
    assign LEDS     = leds_q;
    assign AT_LIMIT = at_limit_q;

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Self-checking bench: two sequencers (step 0x1F4 and 0x2BC) share one set of
// inputs and are compared every cycle against a behavioural position model.
module tb_servo_position_sequencer;

    localparam int TDIV    = 4;
    localparam int LIM_MIN = 'h0AFC8;
    localparam int LIM_MAX = 'h19A28;
    localparam int CEN     = 'h124F8;
    localparam int D0      = 'h1F4;
    localparam int D1      = 'h2BC;

    localparam int MD_HOLD = 0, MD_CENTER = 1, MD_LEFT = 2, MD_RIGHT = 3, MD_SWEEP = 4;

    logic        clk, rst, bc, bl, br, sw;
    logic [19:0] pos0, pos1;
    logic [2:0]  leds0, leds1;
    logic        at0, at1, tick0, tick1;
    logic [24:0] act0, act1;

    assign act0 = {pos0, leds0, at0, tick0};
    assign act1 = {pos1, leds1, at1, tick1};

    int n_cmp = 0;
    int n_bad = 0;

    servo_position_sequencer #(.TICK_DIV(TDIV)) u_dut0 (
        .CLK(clk), .RST(rst), .BC(bc), .BL(bl), .BR(br), .SWEEP(sw),
        .POS(pos0), .LEDS(leds0), .AT_LIMIT(at0), .TICK(tick0)
    );

    servo_position_sequencer #(.TICK_DIV(TDIV), .DELTA(20'h002BC)) u_dut1 (
        .CLK(clk), .RST(rst), .BC(bc), .BL(bl), .BR(br), .SWEEP(sw),
        .POS(pos1), .LEDS(leds1), .AT_LIMIT(at1), .TICK(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int       m_pos [2];
    bit       m_dir [2];   // 1 = heading right
    int       m_mode;
    int       m_cnt;
    int       m_d;
    bit       m_tk;
    bit [3:0] m_h1, m_h2;  // requests seen 1 and 2 edges ago

    function automatic int prio(input bit [3:0] r);
        if (r[3]) return MD_CENTER;
        if (r[2]) return MD_LEFT;
        if (r[1]) return MD_RIGHT;
        if (r[0]) return MD_SWEEP;
        return MD_HOLD;
    endfunction

    function automatic logic [2:0] leds_of(input int mode, input bit dir);
        case (mode)
            MD_CENTER: return 3'b010;
            MD_LEFT:   return 3'b100;
            MD_RIGHT:  return 3'b001;
            MD_SWEEP:  return dir ? 3'b001 : 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic logic [24:0] exp_vec(input int i);
        int p;
        logic [19:0] p20;
        p   = m_pos[i];
        p20 = p[19:0];
        return {p20, leds_of(m_mode, m_dir[i]), (p == LIM_MIN || p == LIM_MAX), (m_cnt == TDIV - 1)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos[0] = CEN; m_pos[1] = CEN;
            m_dir[0] = 1'b1; m_dir[1] = 1'b1;
            m_mode = MD_HOLD; m_cnt = 0; m_h1 = '0; m_h2 = '0;
        end else begin
            m_tk = (m_cnt == TDIV - 1);
            for (int i = 0; i < 2; i++) begin
                m_d = (i == 0) ? D0 : D1;
                case (m_mode)
                    MD_CENTER: m_pos[i] = CEN;
                    MD_LEFT:   if (m_tk) m_pos[i] = (m_pos[i] - m_d < LIM_MIN) ? LIM_MIN : m_pos[i] - m_d;
                    MD_RIGHT:  if (m_tk) m_pos[i] = (m_pos[i] + m_d > LIM_MAX) ? LIM_MAX : m_pos[i] + m_d;
                    MD_SWEEP: if (m_tk) begin
                        if (m_dir[i]) begin
                            m_pos[i] = (m_pos[i] + m_d > LIM_MAX) ? LIM_MAX : m_pos[i] + m_d;
                            if (m_pos[i] == LIM_MAX) m_dir[i] = 1'b0;
                        end else begin
                            m_pos[i] = (m_pos[i] - m_d < LIM_MIN) ? LIM_MIN : m_pos[i] - m_d;
                            if (m_pos[i] == LIM_MIN) m_dir[i] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            m_mode = prio(m_h2);
            m_h2   = m_h1;
            m_h1   = {bc, bl, br, sw};
            m_cnt  = (m_cnt + 1) % TDIV;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        int ticks;
        rst = 1'b1; {bc, bl, br, sw} = 4'b0000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({act0, act1} !== {20'h124F8, 3'b000, 1'b0, 1'b0, 20'h124F8, 3'b000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state act=%h exp=%h", {act0, act1}, {25'h124F80_0, 25'h124F80_0});
        end
        rst = 1'b0;
        ticks = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (tick0) ticks++;
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
        end
        n_cmp++;
        if (ticks !== 4) begin
            n_bad++;
            $display("FAIL tick_rate got=%0d pulses want=4 in 16 cycles", ticks);
        end
    endtask

    task automatic test_left();
        bl = 1'b1;
        for (int c = 0; c < 70 * TDIV + 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL left_ramp cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
        end
        n_cmp++;
        if ({pos0, at0, leds0, pos1, at1} !== {20'h0AFC8, 1'b1, 3'b100, 20'h0AFC8, 1'b1}) begin
            n_bad++;
            $display("FAIL left_limit pos0=%h at0=%b leds0=%b pos1=%h at1=%b want pos=0afc8 at=1 leds=100",
                     pos0, at0, leds0, pos1, at1);
        end
    endtask

    task automatic test_center_priority();
        for (int ph = 0; ph < TDIV; ph++) begin
            bl = 1'b1; bc = 1'b0;
            for (int c = 0; c < 65 * TDIV + ph; c++) begin
                @(negedge clk);
                n_cmp++;
                if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                    n_bad++;
                    $display("FAIL prio_setup ph=%0d cyc=%0d act=%h exp=%h", ph, c, {act0, act1}, {exp_vec(0), exp_vec(1)});
                end
            end
            bc = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                n_cmp++;
                if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                    n_bad++;
                    $display("FAIL prio_model ph=%0d edge=%0d act=%h exp=%h", ph, k, {act0, act1}, {exp_vec(0), exp_vec(1)});
                end
                if (k == 3) begin
                    n_cmp++;
                    if (pos0 !== 20'h0AFC8) begin
                        n_bad++;
                        $display("FAIL prio_early ph=%0d pos0=%h want=0afc8", ph, pos0);
                    end
                end
                if (k == 4) begin
                    n_cmp++;
                    if ({pos0, leds0, pos1} !== {20'h124F8, 3'b010, 20'h124F8}) begin
                        n_bad++;
                        $display("FAIL prio_center ph=%0d pos0=%h leds0=%b pos1=%h want 124f8/010/124f8", ph, pos0, leds0, pos1);
                    end
                end
            end
            bc = 1'b0; bl = 1'b0;
        end
    endtask

    task automatic test_right_clamp();
        logic [19:0] prev1, pre_max;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        br = 1'b1;
        prev1 = pos1; pre_max = '0;
        for (int c = 0; c < 56 * TDIV; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL right_ramp cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
            if (pos1 == 20'h19A28 && prev1 != 20'h19A28) pre_max = prev1;
            prev1 = pos1;
        end
        n_cmp++;
        if (pre_max !== 20'(CEN + 42 * D1)) begin
            n_bad++;
            $display("FAIL right_last_step got=%h want=%h", pre_max, 20'(CEN + 42 * D1));
        end
        n_cmp++;
        if ({pos1, at1, leds1} !== {20'h19A28, 1'b1, 3'b001}) begin
            n_bad++;
            $display("FAIL right_clamp pos1=%h at1=%b leds1=%b want 19a28/1/001", pos1, at1, leds1);
        end
        br = 1'b0;
    endtask

    task automatic test_sweep();
        int ticks, t_max, t_min, t_max2, rises;
        logic [19:0] prev0;
        logic prev_at;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        sw = 1'b1;
        ticks = 0; t_max = -1; t_min = -1; t_max2 = -1; rises = 0;
        prev0 = pos0; prev_at = at0;
        for (int c = 0; c < 1300; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL sweep cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
            if (tick0) ticks++;
            if (at0 && !prev_at) rises++;
            if (pos0 == 20'h19A28 && prev0 != 20'h19A28) begin
                if (t_max < 0) t_max = ticks; else if (t_max2 < 0) t_max2 = ticks;
            end
            if (pos0 == 20'h0AFC8 && prev0 != 20'h0AFC8 && t_min < 0) t_min = ticks;
            prev0 = pos0; prev_at = at0;
        end
        n_cmp++;
        if (t_max < 0 || t_min - t_max !== 120) begin
            n_bad++;
            $display("FAIL sweep_leg_down ticks=%0d want=120 (max@%0d min@%0d)", t_min - t_max, t_max, t_min);
        end
        n_cmp++;
        if (t_min < 0 || t_max2 - t_min !== 120) begin
            n_bad++;
            $display("FAIL sweep_leg_up ticks=%0d want=120 (min@%0d max@%0d)", t_max2 - t_min, t_min, t_max2);
        end
        n_cmp++;
        if (rises !== 3) begin
            n_bad++;
            $display("FAIL sweep_limit_pulses got=%0d want=3", rises);
        end
        sw = 1'b0;
    endtask

    task automatic test_async_reset();
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bl = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (c == 100) begin bl = 1'b0; br = 1'b1; end
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL areset_ramp cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
        end
        @(posedge clk); #2;
        rst = 1'b1; br = 1'b0;
        #1;
        n_cmp++;
        if ({act0, act1} !== {20'h124F8, 3'b000, 1'b0, 1'b0, 20'h124F8, 3'b000, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL areset_immediate act=%h exp=%h", {act0, act1}, {25'h124F80_0, 25'h124F80_0});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                n_bad++;
                $display("FAIL areset_after cyc=%0d act=%h exp=%h", c, {act0, act1}, {exp_vec(0), exp_vec(1)});
            end
        end
        n_cmp++;
        if ({pos0, leds0, pos1, leds1} !== {20'h124F8, 3'b000, 20'h124F8, 3'b000}) begin
            n_bad++;
            $display("FAIL areset_hold pos0=%h leds0=%b pos1=%h leds1=%b want 124f8/000", pos0, leds0, pos1, leds1);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        int hold;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int s = 0; s < 40; s++) begin
            r = 4'($urandom_range(0, 15));
            if (r[3] && $urandom_range(0, 3) != 0) r[3] = 1'b0;
            {bc, bl, br, sw} = r;
            hold = $urandom_range(1, 60);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                n_cmp++;
                if ({act0, act1} !== {exp_vec(0), exp_vec(1)}) begin
                    n_bad++;
                    $display("FAIL random seg=%0d req=%b cyc=%0d act=%h exp=%h", s, r, c, {act0, act1}, {exp_vec(0), exp_vec(1)});
                end
            end
        end
        {bc, bl, br, sw} = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; bc = 1'b0; bl = 1'b0; br = 1'b0; sw = 1'b0;
        test_reset();
        test_left();
        test_center_priority();
        test_right_clamp();
        test_sweep();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
